icache_fetch: RTL and testbench
===============================

# icache_fetch

Direct-mapped, read-only instruction cache between the CPU fetch stage and the instruction port (port 1) of main memory. Hits return the instruction combinationally in the same cycle. Misses stall the CPU while a line fill reads LINE_WORDS sequential words over the slow, strobe-validated memory port. The block also keeps hit and miss counters for performance measurement.

## Interface

**Parameters**
- LINE_WORDS, default 4: words per line; a power of two, at least 2.
- NUM_LINES, default 16: number of lines; a power of two, at least 2.

**Ports**
- MEM_CLK  in  1: the only clock; all state updates on its rising edge.
- RST  in  1: synchronous, active-high reset.
- CPU_ADDR  in  32: fetch byte address. Word address WA = CPU_ADDR[15:2].
- CPU_RDEN  in  1: fetch request.
- CPU_DOUT  out  32: instruction. Equals the cached word on a hit, otherwise 32'h0.
- CPU_HIT  out  1: combinational hit, equal to CPU_RDEN & valid & tag match & state IDLE.
- CPU_STALL  out  1: equal to CPU_RDEN & ~CPU_HIT.
- INVALIDATE  in  1: flush all lines.
- MEM_ADDR1  out  14: word address to main memory. Registered.
- MEM_RDEN1  out  1: read enable to main memory. Registered.
- MEM_DOUT1  in  32: memory read data.
- MEM_VALID1  in  1: memory strobe. MEM_DOUT1 is trustworthy only while this is high.
- HIT_CNT  out  16: hit counter, wraps modulo 2^16.
- MISS_CNT  out  16: miss counter, wraps modulo 2^16.

## Operation

**Address split** (OB = log2 LINE_WORDS, IB = log2 NUM_LINES):
- offset = WA[OB-1:0]
- index = WA[OB+IB-1:OB]
- tag = WA[13:OB+IB]

**Storage:** per line, a valid bit, a tag, and LINE_WORDS data words. Hit reads are combinational from this storage.

**State machine: IDLE, FILL, DONE.**
- IDLE
  - On a miss (CPU_RDEN & ~CPU_HIT):
    - latch the line base {tag, index, 0} and the index;
    - set word counter cnt = 0;
    - drive MEM_ADDR1 = base and MEM_RDEN1 = 1;
    - clear the armed flag;
    - increment MISS_CNT;
    - go to FILL.
  - Each IDLE cycle with a hit increments HIT_CNT.
- FILL
  - armed is set on any cycle where MEM_VALID1 = 0, counting only from the cycle after MEM_ADDR1 last changed.
  - A word is captured in a cycle where armed & MEM_VALID1 = 1. On capture:
    - write MEM_DOUT1 to word cnt of the latched line;
    - if cnt < LINE_WORDS-1: cnt++, MEM_ADDR1++, clear armed.
    - if cnt = LINE_WORDS-1: set the line's tag and valid, drop MEM_RDEN1, go to DONE.
- DONE
  - Go to IDLE after one cycle. The retried fetch then hits.
- CPU_ADDR changes during FILL are ignored. The latched line completes, and the new address is evaluated in IDLE.
- CPU_HIT is 0 in FILL and DONE, so a CPU with CPU_RDEN = 1 stalls there.

**INVALIDATE**
- In any state: clear all valid bits on the next edge.
- In FILL: abort the fill, drop MEM_RDEN1, go to IDLE, and leave the partially written line invalid.
- INVALIDATE has priority over a simultaneous capture.

**Reset**
- State IDLE, all valid bits 0, cnt 0, armed 0.
- MEM_ADDR1 = 0, MEM_RDEN1 = 0, HIT_CNT = 0, MISS_CNT = 0.
- Resulting outputs: CPU_HIT = 0, CPU_DOUT = 0, and CPU_STALL = CPU_RDEN.
- Reset mid-fill abandons the fill; data arrays need not be cleared.

## Timing

- Hit: zero-cycle latency; CPU_DOUT is valid in the same cycle as CPU_ADDR.
- Miss, measured from the first stall cycle:
  - one cycle to launch the fill;
  - per word, wait until armed & MEM_VALID1, which is at least 2 cycles after the address update;
  - one DONE cycle;
  - one IDLE cycle, which hits.
  - With a strobe of period P (high P/2, low P/2), a fill takes about LINE_WORDS·P cycles.
- Counters update on the edge ending the qualifying cycle; MISS_CNT counts once per fill, not once per stall cycle.
- Line-base arithmetic: MEM_ADDR1 increments stay within the line and never carry into the index.

## Test plan

Bench memory model: memory[i] = 32'hA000_0000 + i; MEM_VALID1 toggles every 4 cycles (P = 8); read data is registered one edge after the address.

1. Cold miss at CPU_ADDR 0x0:
   - MEM_ADDR1 steps through 0,1,2,3 with MEM_RDEN1 = 1;
   - each capture happens only after a low→high strobe;
   - CPU_STALL stays high until the fill completes;
   - the fetch then hits with CPU_DOUT = 32'hA000_0000 and MISS_CNT = 1.
2. After test 1, fetch byte addresses 0x4, 0x8, 0xC:
   - each hits in a single cycle with data A000_0001, A000_0002, A000_0003;
   - HIT_CNT increments by 3.
3. Conflict eviction:
   - fetch 0x100 (word 0x40, index 0, tag 1): miss, line refilled with A000_0040..43;
   - refetch 0x0: miss again; MISS_CNT = 3.
4. Strobe stuck high when a fill starts:
   - no capture until MEM_VALID1 has gone low then high again;
   - a stale MEM_DOUT1 = 32'hDEADBEEF is never written.
5. INVALIDATE pulse after word 2 of a fill:
   - state returns to IDLE and MEM_RDEN1 = 0;
   - the next fetch to the same line misses and refills from word 0.
6. RST asserted mid-fill:
   - next cycle: MEM_RDEN1 = 0, MEM_ADDR1 = 0, HIT_CNT = MISS_CNT = 0;
   - a previously cached address now misses.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with strobe-qualified line fill.
// Hits are combinational; misses stall the fetch while the whole line is read.
module icache_fetch #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic        MEM_CLK,
  input  logic        RST,
  input  logic [31:0] CPU_ADDR,
  input  logic        CPU_RDEN,
  output logic [31:0] CPU_DOUT,
  output logic        CPU_HIT,
  output logic        CPU_STALL,
  input  logic        INVALIDATE,
  output logic [13:0] MEM_ADDR1,
  output logic        MEM_RDEN1,
  input  logic [31:0] MEM_DOUT1,
  input  logic        MEM_VALID1,
  output logic [15:0] HIT_CNT,
  output logic [15:0] MISS_CNT
);
  localparam int unsigned OB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TB = 14 - OB - IB;
  localparam int unsigned LB = 14 - OB;

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;
  state_e state_q, state_d;

  logic [13:0]   wa;
  logic [OB-1:0] offset;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;
  logic          unused_addr;

  logic [NUM_LINES-1:0] valid_q;
  logic [TB-1:0]        tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];

  logic [LB-1:0] line_q;
  logic [IB-1:0] line_idx;
  logic [TB-1:0] line_tag;
  logic [OB-1:0] cnt_q, cnt_inc;
  logic          armed_q, rden_q;
  logic [13:0]   addr_q;
  logic [15:0]   hit_cnt_q, miss_cnt_q;
  logic          launch, capture, last;

  assign wa          = CPU_ADDR[15:2];
  assign offset      = wa[OB-1:0];
  assign index       = wa[OB+IB-1:OB];
  assign tag         = wa[13:OB+IB];
  assign unused_addr = ^{CPU_ADDR[31:16], CPU_ADDR[1:0]};

  assign line_idx = line_q[IB-1:0];
  assign line_tag = line_q[LB-1:IB];
  assign cnt_inc  = cnt_q + OB'(1);
  assign last     = (cnt_q == OB'(LINE_WORDS - 1));
  assign launch   = (state_q == StIdle) & CPU_STALL;
  // Strobe must have been seen low since the address last moved, so stale data is never taken.
  assign capture  = (state_q == StFill) & armed_q & MEM_VALID1 & ~INVALIDATE;

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (CPU_STALL) state_d = StFill;
      StFill: begin
        if (INVALIDATE) begin
          state_d = StIdle;
        end else if (capture && last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    CPU_HIT  = 1'b0;
    CPU_DOUT = '0;
    if ((state_q == StIdle) && CPU_RDEN && valid_q[index] && (tag_mem[index] == tag)) begin
      CPU_HIT  = 1'b1;
      CPU_DOUT = data_mem[{index, offset}];
    end
    CPU_STALL = CPU_RDEN & ~CPU_HIT;
  end

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      valid_q    <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      addr_q     <= '0;
      rden_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (INVALIDATE) valid_q <= '0;
      if (CPU_HIT) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (launch) begin
        line_q     <= wa[13:OB];
        cnt_q      <= '0;
        armed_q    <= 1'b0;
        addr_q     <= {wa[13:OB], {OB{1'b0}}};
        rden_q     <= 1'b1;
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end else if (state_q == StFill) begin
        if (INVALIDATE) begin
          rden_q <= 1'b0;
        end else if (capture) begin
          if (last) begin
            rden_q            <= 1'b0;
            valid_q[line_idx] <= 1'b1;
          end else begin
            cnt_q   <= cnt_inc;
            addr_q  <= {line_q, cnt_inc};
            armed_q <= 1'b0;
          end
        end else if (!MEM_VALID1) begin
          armed_q <= 1'b1;
        end
      end
    end
  end

  // Data and tags carry no reset; the valid bits alone qualify them.
  always_ff @(posedge MEM_CLK) begin
    if (capture && !RST) begin
      data_mem[{line_idx, cnt_q}] <= MEM_DOUT1;
      if (last) tag_mem[line_idx] <= line_tag;
    end
  end

  assign MEM_ADDR1 = addr_q;
  assign MEM_RDEN1 = rden_q;
  assign HIT_CNT   = hit_cnt_q;
  assign MISS_CNT  = miss_cnt_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: strobed memory model, vector table for hits,
// hand-written sequences for fills, stuck strobe, invalidate and reset.
module tb_icache_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_rden;
  logic [31:0] cpu_dout;
  logic        cpu_hit;
  logic        cpu_stall;
  logic        invalidate;
  logic [13:0] mem_addr1;
  logic        mem_rden1;
  logic [31:0] mem_dout1 = '0;
  logic        mem_valid1 = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int cyc_cnt = 0;
  int force_until = 0;
  logic [2:0] phase = '0;

  icache_fetch #(.LINE_WORDS(4), .NUM_LINES(16)) dut (
    .MEM_CLK   (clk),
    .RST       (rst),
    .CPU_ADDR  (cpu_addr),
    .CPU_RDEN  (cpu_rden),
    .CPU_DOUT  (cpu_dout),
    .CPU_HIT   (cpu_hit),
    .CPU_STALL (cpu_stall),
    .INVALIDATE(invalidate),
    .MEM_ADDR1 (mem_addr1),
    .MEM_RDEN1 (mem_rden1),
    .MEM_DOUT1 (mem_dout1),
    .MEM_VALID1(mem_valid1),
    .HIT_CNT   (hit_cnt),
    .MISS_CNT  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Memory: data registered one edge after the address; strobe period 8 unless forced high.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    phase   <= phase + 3'd1;
    if (cyc_cnt < force_until) begin
      mem_valid1 <= 1'b1;
      mem_dout1  <= 32'hDEAD_BEEF;
    end else begin
      mem_valid1 <= phase[2];
      mem_dout1  <= 32'hA000_0000 + {18'd0, mem_addr1};
    end
  end

  typedef struct {
    logic        rden;
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_dout;
    logic        exp_stall;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Miss, watch the whole fill, then check the retried fetch hits.
  task automatic do_fill(input string name, input logic [31:0] addr, input logic [31:0] exp_dout);
    logic [13:0] base, prev_addr;
    logic prev_rden, prev_valid, low_seen, order_ok, addr_ok, missed;
    int cyc, nwords;
    base = {addr[15:4], 2'b00};
    cpu_addr = addr;
    cpu_rden = 1'b1;
    #1;
    missed     = cpu_stall;
    prev_rden  = mem_rden1;
    prev_addr  = mem_addr1;
    prev_valid = mem_valid1;
    low_seen = 1'b0; order_ok = 1'b1; addr_ok = 1'b1; cyc = 0; nwords = 0;
    while (cpu_stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!prev_rden && mem_rden1) begin
        if (mem_addr1 != base) addr_ok = 1'b0;
        low_seen = 1'b0;
      end else if (prev_rden && (!mem_rden1 || mem_addr1 != prev_addr)) begin
        nwords++;
        if (!(prev_valid && low_seen)) order_ok = 1'b0;
        if (mem_rden1 && mem_addr1 != prev_addr + 14'd1) addr_ok = 1'b0;
        if (!mem_rden1 && prev_addr != base + 14'd3) addr_ok = 1'b0;
        low_seen = 1'b0;
      end
      if (mem_rden1 && !mem_valid1) low_seen = 1'b1;
      prev_rden  = mem_rden1;
      prev_addr  = mem_addr1;
      prev_valid = mem_valid1;
    end
    exp_miss++;
    check({name, "_missed"}, missed, 1);
    check({name, "_stall_ends"}, cpu_stall, 0);
    check({name, "_words"}, nwords, 4);
    check({name, "_strobe_order"}, order_ok, 1);
    check({name, "_addr_seq"}, addr_ok, 1);
    check({name, "_hit"}, cpu_hit, 1);
    check({name, "_dout"}, cpu_dout, exp_dout);
    check({name, "_miss_cnt"}, miss_cnt, exp_miss);
  endtask

  task automatic hit_probe(input string name, input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr = addr;
    cpu_rden = 1'b1;
    #1;
    check({name, "_hit"}, cpu_hit, 1);
    check({name, "_dout"}, cpu_dout, exp);
    @(negedge clk);
    exp_hits++;
  endtask

  // Look without letting an edge pass, so no fill is launched.
  task automatic miss_probe(input string name, input logic [31:0] addr);
    cpu_addr = addr;
    cpu_rden = 1'b1;
    #1;
    check({name, "_stall"}, cpu_stall, 1);
    check({name, "_hit"}, cpu_hit, 0);
    cpu_rden = 1'b0;
  endtask

  task automatic wait_addr(input string name, input logic [13:0] target);
    int cyc;
    cyc = 0;
    while (!(mem_rden1 && mem_addr1 == target) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_reached"}, mem_addr1, target);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h4, 1'b1, 32'hA000_0001, 1'b0};
    vecs[1] = '{1'b1, 32'h8, 1'b1, 32'hA000_0002, 1'b0};
    vecs[2] = '{1'b1, 32'hC, 1'b1, 32'hA000_0003, 1'b0};
    vecs[3] = '{1'b0, 32'hC, 1'b0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h0, 1'b1, 32'hA000_0000, 1'b0};
    vecs[5] = '{1'b0, 32'h4, 1'b0, 32'h0, 1'b0};

    rst = 1'b1; cpu_addr = '0; cpu_rden = 1'b0; invalidate = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hit", cpu_hit, 0);
    check("rst_dout", cpu_dout, 0);
    check("rst_stall_idle", cpu_stall, 0);
    check("rst_mem_rden", mem_rden1, 0);
    check("rst_mem_addr", mem_addr1, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    cpu_rden = 1'b1;
    #1;
    check("rst_stall_rden", cpu_stall, 1);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, then hits from the table
    do_fill("cold", 32'h0, 32'hA000_0000);
    for (int i = 0; i < 6; i++) begin
      cpu_rden = vecs[i].rden;
      cpu_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_hit", i), cpu_hit, vecs[i].exp_hit);
      check($sformatf("vec%0d_dout", i), cpu_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].exp_stall);
      @(negedge clk);
      if (vecs[i].rden && vecs[i].exp_hit) exp_hits++;
    end
    check("table_hit_cnt", hit_cnt, exp_hits);
    check("table_miss_cnt", miss_cnt, exp_miss);

    // Conflict eviction on index 0
    do_fill("evict", 32'h100, 32'hA000_0040);
    hit_probe("evict_w3", 32'h10C, 32'hA000_0043);
    do_fill("refetch", 32'h0, 32'hA000_0000);

    // Strobe stuck high (with stale data) when the fill starts
    force_until = cyc_cnt + 6;
    do_fill("stuck", 32'h20, 32'hA000_0008);
    hit_probe("stuck_w1", 32'h24, 32'hA000_0009);
    hit_probe("stuck_w2", 32'h28, 32'hA000_000A);
    hit_probe("stuck_w3", 32'h2C, 32'hA000_000B);

    // Invalidate part way through a fill
    cpu_addr = 32'h40;
    cpu_rden = 1'b1;
    wait_addr("inv", 14'h12);
    exp_miss++;
    invalidate = 1'b1;
    cpu_rden = 1'b0;
    @(negedge clk);
    invalidate = 1'b0;
    check("inv_mem_rden", mem_rden1, 0);
    check("inv_miss_cnt", miss_cnt, exp_miss);
    miss_probe("inv_line0", 32'h0);
    miss_probe("inv_line2", 32'h24);
    do_fill("inv_refill", 32'h40, 32'hA000_0010);
    check("pre_rst_hit_cnt", hit_cnt, exp_hits);

    // Reset part way through a fill
    cpu_addr = 32'h80;
    cpu_rden = 1'b1;
    wait_addr("rstfill", 14'h21);
    rst = 1'b1;
    cpu_rden = 1'b0;
    @(negedge clk);
    check("midrst_mem_rden", mem_rden1, 0);
    check("midrst_mem_addr", mem_addr1, 0);
    check("midrst_hit_cnt", hit_cnt, 0);
    check("midrst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    miss_probe("midrst_cached", 32'h40);
    do_fill("after_rst", 32'h80, 32'hA000_0020);
    hit_probe("after_rst_w1", 32'h84, 32'hA000_0021);
    cpu_rden = 1'b0;
    #1;
    check("final_hit_cnt", hit_cnt, exp_hits);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
